// File: rtl/vocoder_mixer_if.sv
// Bundles the vocoder_mixer data/strobe bus.
// The filterbank side is the master; the mixer itself is the slave.
interface vocoder_mixer_if #(
    parameter int N_CHANNELS    = 12,
    parameter int CARRIER_WIDTH = 32,
    parameter int ENV_WIDTH     = 32,
    parameter int OUT_WIDTH     = 24
);
    logic                                        valid_in;
    logic [N_CHANNELS-1:0][CARRIER_WIDTH-1:0]    carrier_in;
    logic [N_CHANNELS-1:0][ENV_WIDTH-1:0]        envelope_in;
    logic [N_CHANNELS-1:0]                       chan_en_in;
    logic [3:0]                                  gain_shift_in;
    logic                                        peak_clr_in;
    logic signed [OUT_WIDTH-1:0]                 sample_out;
    logic                                        valid_out;
    logic                                        busy_out;
    logic                                        overrun_out;
    logic                                        sat_out;
    logic [OUT_WIDTH-2:0]                        peak_out;

    modport master (
        output valid_in, carrier_in, envelope_in, chan_en_in, gain_shift_in, peak_clr_in,
        input  sample_out, valid_out, busy_out, overrun_out, sat_out, peak_out
    );

    modport slave (
        input  valid_in, carrier_in, envelope_in, chan_en_in, gain_shift_in, peak_clr_in,
        output sample_out, valid_out, busy_out, overrun_out, sat_out, peak_out
    );
endinterface

// File: rtl/vocoder_mixer.sv
// Vocoder output mixer: sum over bands of carrier*envelope through one shared
// multiplier, master arithmetic shift, saturation to the DAC width.
// Optional peak-magnitude hold is enabled with `define MIXER_PEAK_HOLD_EN.
//
// state | meaning
// IDLE  | waiting for valid_in; inputs latched into shadow registers on it
// MAC   | one band multiplied per cycle, previous product accumulated
// DRAIN | last product accumulated
// OUT   | shift, saturate, register sample_out, pulse valid_out
module vocoder_mixer #(
    parameter int N_CHANNELS    = 12,
    parameter int CARRIER_WIDTH = 32,
    parameter int ENV_WIDTH     = 32,
    parameter int ENV_FRAC      = 16,
    parameter int OUT_WIDTH     = 24,
    parameter int ACC_WIDTH     = CARRIER_WIDTH + ENV_WIDTH + $clog2(N_CHANNELS)
) (
    input  logic           clk_in,
    input  logic           rst_in,
    vocoder_mixer_if.slave mix
);
    localparam int PROD_W = CARRIER_WIDTH + ENV_WIDTH;
    localparam int IDX_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHANNELS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    state_t state, state_nxt;
    logic   start, mac_step, acc_step, out_load, overrun_hit;

    logic [N_CHANNELS-1:0][CARRIER_WIDTH-1:0] carrier_sh;
    logic [N_CHANNELS-1:0][ENV_WIDTH-1:0]     env_sh;
    logic [N_CHANNELS-1:0]                    en_sh;
    logic [3:0]                               shift_sh;
    logic [IDX_W-1:0]                         idx;

    logic signed [CARRIER_WIDTH-1:0] car_sel;
    logic signed [ENV_WIDTH-1:0]     env_sel;
    logic signed [PROD_W-1:0]        prod_nxt, prod_reg, prod_scaled;
    logic signed [ACC_WIDTH-1:0]     prod_ext, acc, shifted;
    logic signed [OUT_WIDTH-1:0]     sat_val;
    logic                            clip;

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; OUT always returns to IDLE so a mix never stalls.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mix.valid_in) state_nxt = MAC;
            MAC:     if (idx == LAST_IDX) state_nxt = DRAIN;
            DRAIN:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        start       = (state == IDLE) && mix.valid_in;
        mac_step    = (state == MAC);
        acc_step    = (state == MAC) || (state == DRAIN);
        out_load    = (state == OUT);
        overrun_hit = (state != IDLE) && mix.valid_in;
    end

    // Band select, full-width signed product, and scaled/saturated result.
    // Sign-extended operands make the unsigned multiply exact in two's complement.
    always_comb begin
        car_sel     = carrier_sh[idx];
        env_sel     = env_sh[idx];
        prod_nxt    = {{ENV_WIDTH{car_sel[CARRIER_WIDTH-1]}}, car_sel} *
                      {{CARRIER_WIDTH{env_sel[ENV_WIDTH-1]}}, env_sel};
        prod_scaled = prod_reg >>> ENV_FRAC;
        prod_ext    = ACC_WIDTH'(prod_scaled);
        shifted     = acc >>> shift_sh;
        clip        = 1'b0;
        sat_val     = shifted[OUT_WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            clip    = 1'b1;
            sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            clip    = 1'b1;
            sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    // Shadow capture, MAC pipeline and output registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            carrier_sh      <= '0;
            env_sh          <= '0;
            en_sh           <= '0;
            shift_sh        <= '0;
            idx             <= '0;
            prod_reg        <= '0;
            acc             <= '0;
            mix.sample_out  <= '0;
            mix.valid_out   <= 1'b0;
            mix.sat_out     <= 1'b0;
            mix.busy_out    <= 1'b0;
            mix.overrun_out <= 1'b0;
        end else begin
            if (start) begin
                carrier_sh <= mix.carrier_in;
                env_sh     <= mix.envelope_in;
                en_sh      <= mix.chan_en_in;
                shift_sh   <= mix.gain_shift_in;
                idx        <= '0;
                prod_reg   <= '0;
                acc        <= '0;
            end
            if (mac_step) begin
                prod_reg <= en_sh[idx] ? prod_nxt : '0;
                if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
            end
            if (acc_step) acc <= acc + prod_ext;
            if (out_load) begin
                mix.sample_out <= sat_val;
            end
            mix.valid_out   <= out_load;
            mix.sat_out     <= out_load && clip;
            mix.busy_out    <= (state_nxt != IDLE);
            mix.overrun_out <= mix.overrun_out || overrun_hit;
        end
    end

`ifdef MIXER_PEAK_HOLD_EN
    logic [OUT_WIDTH-1:0] neg_full;
    logic [OUT_WIDTH-2:0] mag;

    // Magnitude of the current sample; the most negative code clamps to full scale.
    always_comb begin
        neg_full = ~mix.sample_out + OUT_WIDTH'(1);
        if (!mix.sample_out[OUT_WIDTH-1])
            mag = mix.sample_out[OUT_WIDTH-2:0];
        else if (mix.sample_out == {1'b1, {(OUT_WIDTH-1){1'b0}}})
            mag = '1;
        else
            mag = neg_full[OUT_WIDTH-2:0];
    end

    // Peak hold; a clear request wins over a coincident update.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)                                mix.peak_out <= '0;
        else if (mix.peak_clr_in)                  mix.peak_out <= '0;
        else if (mix.valid_out && mag > mix.peak_out) mix.peak_out <= mag;
    end
`else
    assign mix.peak_out = '0;
`endif

endmodule

// File: tb/tb_vocoder_mixer.sv
// Directed-vector bench for vocoder_mixer at default parameters.
module tb_vocoder_mixer;
    localparam int N  = 12;
    localparam int CW = 32;
    localparam int EW = 32;
    localparam int OW = 24;

    logic clk_98_3mhz = 1'b0;
    logic rst;
    int   n_vec     = 0;
    int   n_miscmp  = 0;

    always #5 clk_98_3mhz = ~clk_98_3mhz;

    vocoder_mixer_if #(.N_CHANNELS(N), .CARRIER_WIDTH(CW), .ENV_WIDTH(EW), .OUT_WIDTH(OW)) mix_if ();

    vocoder_mixer #(
        .N_CHANNELS(N), .CARRIER_WIDTH(CW), .ENV_WIDTH(EW), .ENV_FRAC(16), .OUT_WIDTH(OW)
    ) dut (
        .clk_in (clk_98_3mhz),
        .rst_in (rst),
        .mix    (mix_if)
    );

    task automatic check_vec(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_bands(input int car, input int env, input logic [N-1:0] en,
                             input logic [3:0] sh);
        for (int i = 0; i < N; i++) begin
            mix_if.carrier_in[i]  = 32'(car);
            mix_if.envelope_in[i] = 32'(env);
        end
        mix_if.chan_en_in    = en;
        mix_if.gain_shift_in = sh;
    endtask

    // Pulses valid_in, optionally injects a second valid_in (with carriers=7)
    // at cycle inj_at, and waits a bounded time for valid_out.
    task automatic do_mix(input int inj_at, output logic signed [OW-1:0] smp,
                          output logic sat, output int lat, output logic busy1,
                          output logic busy_end);
        logic got;
        got = 1'b0; lat = 0; smp = '0; sat = 1'b0; busy1 = 1'b0; busy_end = 1'b1;
        @(negedge clk_98_3mhz);
        mix_if.valid_in = 1'b1;
        while (!got && lat < 40) begin
            @(negedge clk_98_3mhz);
            lat++;
            mix_if.valid_in = (lat == inj_at);
            if (lat == inj_at)
                for (int i = 0; i < N; i++) mix_if.carrier_in[i] = 32'd7;
            if (lat == 1) busy1 = mix_if.busy_out;
            if (mix_if.valid_out) begin
                got      = 1'b1;
                smp      = mix_if.sample_out;
                sat      = mix_if.sat_out;
                busy_end = mix_if.busy_out;
            end
        end
        mix_if.valid_in = 1'b0;
        if (!got) check_vec("valid_out_timeout", 64'sd0, 64'sd1);
        @(negedge clk_98_3mhz);
        check_vec("valid_out_one_cycle", 64'(mix_if.valid_out), 64'sd0);
    endtask

    task automatic mix_expect(input string tag, input int exp_smp, input logic exp_sat);
        logic signed [OW-1:0] smp;
        logic sat, busy1, busy_end;
        int lat;
        do_mix(0, smp, sat, lat, busy1, busy_end);
        check_vec({tag, "_sample"}, smp, 64'(exp_smp));
        check_vec({tag, "_sat"}, 64'(sat), 64'(exp_sat));
    endtask

    task automatic count_quiet(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_98_3mhz);
            if (mix_if.valid_out) hits++;
        end
        check_vec(tag, 64'(hits), 64'sd0);
    endtask

    initial begin
        logic signed [OW-1:0] smp;
        logic sat, busy1, busy_end;
        int lat;

        rst = 1'b1;
        mix_if.valid_in    = 1'b0;
        mix_if.peak_clr_in = 1'b0;
        set_bands(0, 0, '0, 4'd0);
        repeat (3) @(negedge clk_98_3mhz);
        check_vec("rst_sample", mix_if.sample_out, 64'sd0);
        check_vec("rst_valid", 64'(mix_if.valid_out), 64'sd0);
        check_vec("rst_busy", 64'(mix_if.busy_out), 64'sd0);
        check_vec("rst_overrun", 64'(mix_if.overrun_out), 64'sd0);
        check_vec("rst_sat", 64'(mix_if.sat_out), 64'sd0);
        check_vec("rst_peak", 64'(mix_if.peak_out), 64'sd0);
        rst = 1'b0;
        @(negedge clk_98_3mhz);

        // Unity weights: 12 x 1000, full latency and busy profile.
        set_bands(1000, 65536, '1, 4'd0);
        do_mix(0, smp, sat, lat, busy1, busy_end);
        check_vec("unity_latency", 64'(lat), 64'sd15);
        check_vec("unity_sample", smp, 64'sd12000);
        check_vec("unity_sat", 64'(sat), 64'sd0);
        check_vec("unity_busy_rise", 64'(busy1), 64'sd1);
        check_vec("unity_busy_fall", 64'(busy_end), 64'sd0);

        set_bands(-500, 32768, 12'h00F, 4'd1);
        mix_expect("mask_neg", -500, 1'b0);
        set_bands(8388607, 65536, '1, 4'd0);
        mix_expect("sat_pos", 8388607, 1'b1);
        set_bands(-8388607, 65536, '1, 4'd0);
        mix_expect("sat_neg", -8388608, 1'b1);
        set_bands(1000, 65536, '0, 4'd0);
        mix_expect("all_masked", 0, 1'b0);
        set_bands(1000, 65536, '1, 4'd3);
        mix_expect("shift3", 1500, 1'b0);
        set_bands(-1, 65536, '1, 4'd5);
        mix_expect("floor_shift", -1, 1'b0);
        set_bands(-3, 32768, '1, 4'd0);
        mix_expect("floor_frac", -24, 1'b0);
        set_bands(4000, 65536, '1, 4'd15);
        mix_expect("shift15", 1, 1'b0);
        check_vec("no_overrun_yet", 64'(mix_if.overrun_out), 64'sd0);

        // Overrun: second strobe 5 cycles in carries carriers=7, must be dropped.
        set_bands(1000, 65536, '1, 4'd0);
        do_mix(5, smp, sat, lat, busy1, busy_end);
        check_vec("ovr_sample", smp, 64'sd12000);
        check_vec("ovr_latency", 64'(lat), 64'sd15);
        check_vec("ovr_flag", 64'(mix_if.overrun_out), 64'sd1);
        count_quiet("ovr_single_valid", 20);
        mix_expect("after_ovr", 84, 1'b0);
        check_vec("ovr_sticky", 64'(mix_if.overrun_out), 64'sd1);

        // Reset mid-mix, 6 cycles after the strobe.
        set_bands(1000, 65536, '1, 4'd0);
        @(negedge clk_98_3mhz);
        mix_if.valid_in = 1'b1;
        @(negedge clk_98_3mhz);
        mix_if.valid_in = 1'b0;
        repeat (5) @(negedge clk_98_3mhz);
        check_vec("pre_rst_busy", 64'(mix_if.busy_out), 64'sd1);
        rst = 1'b1;
        #1;
        check_vec("midrst_busy", 64'(mix_if.busy_out), 64'sd0);
        check_vec("midrst_sample", mix_if.sample_out, 64'sd0);
        check_vec("midrst_overrun", 64'(mix_if.overrun_out), 64'sd0);
        @(negedge clk_98_3mhz);
        rst = 1'b0;
        count_quiet("midrst_no_valid", 20);
        mix_expect("post_rst", 12000, 1'b0);

`ifdef MIXER_PEAK_HOLD_EN
        @(negedge clk_98_3mhz);
        mix_if.peak_clr_in = 1'b1;
        @(negedge clk_98_3mhz);
        mix_if.peak_clr_in = 1'b0;
        check_vec("peak_clr0", 64'(mix_if.peak_out), 64'sd0);
        set_bands(100, 65536, 12'h001, 4'd0);
        mix_expect("peak_a", 100, 1'b0);
        set_bands(-3000, 65536, 12'h001, 4'd0);
        mix_expect("peak_b", -3000, 1'b0);
        set_bands(2000, 65536, 12'h001, 4'd0);
        mix_expect("peak_c", 2000, 1'b0);
        check_vec("peak_hold", 64'(mix_if.peak_out), 64'sd3000);
        mix_if.peak_clr_in = 1'b1;
        @(negedge clk_98_3mhz);
        mix_if.peak_clr_in = 1'b0;
        check_vec("peak_clr", 64'(mix_if.peak_out), 64'sd0);
        set_bands(-8388608, 65536, 12'h001, 4'd0);
        mix_expect("peak_min", -8388608, 1'b0);
        check_vec("peak_min_mag", 64'(mix_if.peak_out), 64'sd8388607);
`else
        check_vec("peak_tied_zero", 64'(mix_if.peak_out), 64'sd0);
        mix_if.peak_clr_in = 1'b1;
        @(negedge clk_98_3mhz);
        mix_if.peak_clr_in = 1'b0;
        check_vec("peak_clr_ignored", 64'(mix_if.peak_out), 64'sd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
